fifo_read_streamer: RTL

- Read-side consumer for the dual-clock FIFO; lives entirely in the read clock domain.
- Drives the FIFO pop strobe and captures the registered read data.
- Re-presents that data as a valid/ready stream through a 2-entry output buffer, so downstream backpressure never loses or duplicates a word.
- Keeps a running count of delivered words for debug and throughput checks.

---
 rtl/fifo_read_streamer.sv | 75 +++++++
 1 files changed

// File: rtl/fifo_read_streamer.sv
// Read-side consumer for a dual-clock FIFO: issues pops, captures the registered
// read data and re-presents it as a valid/ready stream through a 2-entry buffer.
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  logic                  pend_reg;
  logic [1:0]            occ_reg;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] skid_reg;
  logic                  valid_reg;
  logic [CNT_WIDTH-1:0]  count_reg;

  logic       pop;
  logic [2:0] inflight;
  logic [1:0] occ_after_pop;
  logic [1:0] occ_next;

  always_comb begin
    pop           = valid_reg & m_ready;
    inflight      = {1'b0, occ_reg} + {2'b00, pend_reg};
    // Only request a word if it is guaranteed a slot once it arrives.
    fifo_r_en     = enable & ~fifo_empty & ~rst & ((inflight - {2'b00, pop}) < 3'd2);
    occ_after_pop = occ_reg - {1'b0, pop};
    occ_next      = occ_after_pop + {1'b0, pend_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg  <= 1'b0;
      occ_reg   <= 2'd0;
      out_reg   <= '0;
      skid_reg  <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      pend_reg  <= fifo_r_en;
      occ_reg   <= occ_next;
      valid_reg <= (occ_next != 2'd0);
      if (pop) begin
        count_reg <= count_reg + CNT_WIDTH'(1);
      end
      if (pop && (occ_reg == 2'd2)) begin
        out_reg <= skid_reg;
      end
      // Arriving word lands in whichever slot is the first free one after the pop.
      if (pend_reg) begin
        if (occ_after_pop == 2'd0) begin
          out_reg <= fifo_data;
        end else begin
          skid_reg <= fifo_data;
        end
      end
    end
  end

  assign m_valid    = valid_reg;
  assign m_data     = out_reg;
  assign word_count = count_reg;
  assign busy       = pend_reg | (occ_reg != 2'd0);

endmodule
